// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit_mc
//  Purpose  : Pipeline hazard control with forwarding, multiply/divide busy
//             tracking with timeout, memory-wait freeze and a stall counter.
//  Revision : 1.0
// ============================================================================
module hazard_unit_mc #(
   parameter int         REG_AW        = 5,
   parameter logic [1:0] LOAD_RESULT   = 2'b01,
   parameter int         MD_MAX_CYCLES = 34,
   parameter int         CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] Rs1E,
   input  logic [REG_AW-1:0] Rs2E,
   input  logic [REG_AW-1:0] RdE,
   input  logic [1:0]        PCSrcE,
   input  logic [1:0]        ResultSrcE,
   input  logic              MulDivStartE,
   input  logic              MulDivDoneE,
   input  logic [REG_AW-1:0] RdM,
   input  logic              RegWriteM,
   input  logic              LoadPendingM,
   input  logic              MemReadyM,
   input  logic [REG_AW-1:0] RdW,
   input  logic              RegWriteW,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              StallM,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushM,
   output logic              FlushW,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              MdTimeout,
   output logic [CNT_W-1:0]  StallCount
);

   localparam int                 c_MD_CW  = $clog2(MD_MAX_CYCLES + 1);
   localparam logic [c_MD_CW-1:0] c_MD_MAX = c_MD_CW'(MD_MAX_CYCLES);

   typedef enum logic [0:0] {
      S_RUN     = 1'b0,
      S_MD_BUSY = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_MD_CW-1:0] r_md_cnt;
   logic [c_MD_CW-1:0] w_md_cnt_nxt;
   logic               r_md_timeout;
   logic [CNT_W-1:0]   r_stall_cnt;

   logic w_timeout;
   logic w_mem_wait;
   logic w_md_stall;
   logic w_lu;
   logic w_br;

   always_comb begin
      w_state_nxt  = r_state;
      w_md_cnt_nxt = r_md_cnt;
      w_timeout    = 1'b0;
      case (r_state)
         S_RUN: begin
            if (MulDivStartE && !MulDivDoneE) begin
               w_state_nxt  = S_MD_BUSY;
               w_md_cnt_nxt = c_MD_CW'(1);
            end
         end
         S_MD_BUSY: begin
            if (MulDivDoneE) begin
               w_state_nxt  = S_RUN;
               w_md_cnt_nxt = '0;
            end else if (r_md_cnt == c_MD_MAX) begin
               w_state_nxt  = S_RUN;
               w_md_cnt_nxt = '0;
               w_timeout    = 1'b1;
            end else begin
               w_md_cnt_nxt = r_md_cnt + c_MD_CW'(1);
            end
         end
         default: begin
            w_state_nxt  = S_RUN;
            w_md_cnt_nxt = '0;
         end
      endcase
   end

   assign w_mem_wait = LoadPendingM & ~MemReadyM;
   // The timeout cycle releases the stall so the pipeline is never wedged.
   assign w_md_stall = ((r_state == S_RUN) & MulDivStartE & ~MulDivDoneE) |
                       ((r_state == S_MD_BUSY) & ~MulDivDoneE & ~w_timeout);
   assign w_lu       = (ResultSrcE == LOAD_RESULT) && (RdE != '0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
   assign w_br       = |PCSrcE;

   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      FlushW    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (rst) begin
         if (RegWriteM && (RdM == Rs1E) && (Rs1E != '0))      ForwardAE = 2'b10;
         else if (RegWriteW && (RdW == Rs1E) && (Rs1E != '0)) ForwardAE = 2'b01;
         if (RegWriteM && (RdM == Rs2E) && (Rs2E != '0))      ForwardBE = 2'b10;
         else if (RegWriteW && (RdW == Rs2E) && (Rs2E != '0)) ForwardBE = 2'b01;

         if (w_mem_wait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (w_md_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
         end else if (w_br) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (w_lu) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_RUN;
         r_md_cnt     <= '0;
         r_md_timeout <= 1'b0;
         r_stall_cnt  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_md_cnt <= w_md_cnt_nxt;
         if (w_timeout)
            r_md_timeout <= 1'b1;
         if (StallF && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign MdTimeout  = r_md_timeout;
   assign StallCount = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_unit_mc
//  Purpose  : Scoreboard bench for hazard_unit_mc (MD_MAX_CYCLES = 4).
//  Revision : 1.0
// ============================================================================
module tb_hazard_unit_mc;

   typedef struct packed {
      logic [3:0]  stall;   // F D E M
      logic [3:0]  flush;   // D E M W
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        to;
      logic [15:0] cnt;
   } out_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic [1:0] PCSrcE, ResultSrcE, ForwardAE, ForwardBE;
   logic       MulDivStartE, MulDivDoneE, RegWriteM, LoadPendingM, MemReadyM, RegWriteW;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MdTimeout;
   logic [15:0] StallCount;

   out_t obs, e, x;
   out_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic [15:0] m_cnt = '0;
   logic        m_to  = 1'b0;

   always #5 clk = ~clk;

   hazard_unit_mc #(.REG_AW(5), .LOAD_RESULT(2'b01), .MD_MAX_CYCLES(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .PCSrcE(PCSrcE), .ResultSrcE(ResultSrcE),
      .MulDivStartE(MulDivStartE), .MulDivDoneE(MulDivDoneE),
      .RdM(RdM), .RegWriteM(RegWriteM), .LoadPendingM(LoadPendingM), .MemReadyM(MemReadyM),
      .RdW(RdW), .RegWriteW(RegWriteW),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .MdTimeout(MdTimeout), .StallCount(StallCount)
   );

   assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
                 ForwardAE, ForwardBE, MdTimeout, StallCount};

   function automatic out_t mk(input logic [3:0] s, input logic [3:0] f,
                               input logic [1:0] a, input logic [1:0] b);
      mk = '{stall: s, flush: f, fa: a, fb: b, to: m_to, cnt: m_cnt};
   endfunction

   task automatic idle();
      Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
      PCSrcE = '0; ResultSrcE = '0; MulDivStartE = 0; MulDivDoneE = 0;
      RegWriteM = 0; LoadPendingM = 0; MemReadyM = 0; RegWriteW = 0;
   endtask

   // Advance one clock and update the reference model of the registered outputs.
   task automatic advance(input out_t cur);
      @(posedge clk);
      #1;
      if (!rst) begin
         m_cnt = '0;
         m_to  = 1'b0;
      end else if (cur.stall[3] && m_cnt != 16'hFFFF) begin
         m_cnt = m_cnt + 16'd1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; idle();
      RegWriteM = 1; RdM = 5; Rs1E = 5; LoadPendingM = 1; PCSrcE = 2'b01;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin rst = 1'b1; idle(); end
         sb.push_back(mk(4'b0000, 4'b0000, 2'b00, 2'b00));
         @(negedge clk); x = sb.pop_front(); checks++;
         if (obs !== x) begin errors++; $display("FAIL reset[%0d]: got %h required %h", i, obs, x); end
         advance(x);
      end
   endtask

   task automatic test_forward();
      for (int i = 0; i < 5; i++) begin
         idle();
         RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 9; RegWriteM = 1; RegWriteW = 1;
         case (i)
            0: e = mk(4'b0000, 4'b0000, 2'b10, 2'b00);
            1: begin RegWriteM = 0; e = mk(4'b0000, 4'b0000, 2'b01, 2'b00); end
            2: begin Rs1E = 0; RdM = 0; RdW = 0; e = mk(4'b0000, 4'b0000, 2'b00, 2'b00); end
            3: begin RdW = 9; e = mk(4'b0000, 4'b0000, 2'b10, 2'b01); end
            default: begin RegWriteM = 0; RegWriteW = 0; e = mk(4'b0000, 4'b0000, 2'b00, 2'b00); end
         endcase
         sb.push_back(e);
         @(negedge clk); x = sb.pop_front(); checks++;
         if (obs !== x) begin errors++; $display("FAIL fwd[%0d]: got %h required %h", i, obs, x); end
         advance(x);
      end
   endtask

   task automatic test_load_use();
      for (int i = 0; i < 4; i++) begin
         idle();
         case (i)
            0: begin ResultSrcE = 2'b01; RdE = 3; Rs2D = 3; e = mk(4'b1100, 4'b0100, 2'b00, 2'b00); end
            1: e = mk(4'b0000, 4'b0000, 2'b00, 2'b00);
            2: begin ResultSrcE = 2'b01; RdE = 0; e = mk(4'b0000, 4'b0000, 2'b00, 2'b00); end
            default: begin ResultSrcE = 2'b10; RdE = 4; Rs1D = 4; e = mk(4'b0000, 4'b0000, 2'b00, 2'b00); end
         endcase
         sb.push_back(e);
         @(negedge clk); x = sb.pop_front(); checks++;
         if (obs !== x) begin errors++; $display("FAIL loaduse[%0d]: got %h required %h", i, obs, x); end
         advance(x);
      end
   endtask

   task automatic test_branch_vs_lu();
      for (int i = 0; i < 2; i++) begin
         idle();
         if (i == 0) begin ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; PCSrcE = 2'b01; end
         else PCSrcE = 2'b10;
         sb.push_back(mk(4'b0000, 4'b1100, 2'b00, 2'b00));
         @(negedge clk); x = sb.pop_front(); checks++;
         if (obs !== x) begin errors++; $display("FAIL branch[%0d]: got %h required %h", i, obs, x); end
         advance(x);
      end
   endtask

   task automatic test_muldiv();
      for (int i = 0; i < 7; i++) begin
         idle();
         MulDivStartE = (i <= 5);
         MulDivDoneE  = (i >= 4 && i <= 5);
         if (i < 4) e = mk(4'b1110, 4'b0010, 2'b00, 2'b00);
         else       e = mk(4'b0000, 4'b0000, 2'b00, 2'b00);
         sb.push_back(e);
         @(negedge clk); x = sb.pop_front(); checks++;
         if (obs !== x) begin errors++; $display("FAIL muldiv[%0d]: got %h required %h", i, obs, x); end
         advance(x);
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 7; i++) begin
         idle();
         MulDivStartE = (i <= 4);
         if (i < 4) e = mk(4'b1110, 4'b0010, 2'b00, 2'b00);
         else       e = mk(4'b0000, 4'b0000, 2'b00, 2'b00);
         sb.push_back(e);
         @(negedge clk); x = sb.pop_front(); checks++;
         if (obs !== x) begin errors++; $display("FAIL timeout[%0d]: got %h required %h", i, obs, x); end
         if (i == 4) m_to = 1'b1;
         advance(x);
      end
   endtask

   task automatic test_mem_wait();
      for (int i = 0; i < 4; i++) begin
         idle();
         LoadPendingM = 1; MemReadyM = (i == 3); PCSrcE = 2'b01;
         RegWriteM = 1; RdM = 7; Rs1E = 7;
         if (i < 3) e = mk(4'b1111, 4'b0001, 2'b10, 2'b00);
         else       e = mk(4'b0000, 4'b1100, 2'b10, 2'b00);
         sb.push_back(e);
         @(negedge clk); x = sb.pop_front(); checks++;
         if (obs !== x) begin errors++; $display("FAIL memwait[%0d]: got %h required %h", i, obs, x); end
         advance(x);
      end
   endtask

   task automatic test_reset_mid_md();
      for (int i = 0; i < 4; i++) begin
         idle();
         rst = (i != 2);
         MulDivStartE = (i <= 2);
         if (i < 2) e = mk(4'b1110, 4'b0010, 2'b00, 2'b00);
         else       e = mk(4'b0000, 4'b0000, 2'b00, 2'b00);
         sb.push_back(e);
         @(negedge clk); x = sb.pop_front(); checks++;
         if (obs !== x) begin errors++; $display("FAIL rstmd[%0d]: got %h required %h", i, obs, x); end
         advance(x);
      end
   endtask

   initial begin
      rst = 1'b0; idle();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_forward();
      test_load_use();
      test_branch_vs_lu();
      test_muldiv();
      test_timeout();
      test_mem_wait();
      test_reset_mid_md();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: got %0d leftover entries required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
